// File: rtl/wb_pkg.sv
// Shared definitions for the regfile write-back path: requester indices,
// round-robin pointer type and the pointer-advance helper.
package wb_pkg;

  localparam int NREQ = 3;

  typedef logic [1:0] rr_ptr_t;

  localparam rr_ptr_t WB_ALU  = 2'd0;
  localparam rr_ptr_t WB_MDU  = 2'd1;
  localparam rr_ptr_t WB_LOAD = 2'd2;

  // Advance modulo 3; the unused encoding 3 folds back to ALU.
  function automatic rr_ptr_t rr_next(input rr_ptr_t idx);
    rr_ptr_t nxt;
    case (idx)
      WB_ALU:  nxt = WB_MDU;
      WB_MDU:  nxt = WB_LOAD;
      default: nxt = WB_ALU;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant from the valid vector and the
// current pointer, plus the pointer value to load after this cycle.
module rr_arbiter3
  import wb_pkg::*;
(
  input  logic [2:0] req_valid,
  input  rr_ptr_t    rr_ptr,
  output logic [2:0] grant,
  output logic       grant_any,
  output rr_ptr_t    grant_idx,
  output rr_ptr_t    next_ptr
);

  rr_ptr_t start;
  rr_ptr_t cand;

  always_comb begin
    grant     = 3'b000;
    grant_any = 1'b0;
    grant_idx = WB_ALU;
    start     = (rr_ptr == 2'd3) ? WB_ALU : rr_ptr;
    cand      = start;
    // Scan ptr, ptr+1, ptr+2 (mod 3); the first valid one wins.
    for (int k = 0; k < 3; k++) begin
      if (!grant_any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_any   = 1'b1;
        grant_idx   = cand;
      end
      cand = rr_next(cand);
    end
    next_ptr = grant_any ? rr_next(grant_idx) : rr_ptr;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/MDU/LOAD results onto the single
// regfile write port and tracks in-flight destinations in a scoreboard.
module regfile_wb_ctrl #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic              iss_ready,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_rd,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wea,
  output logic [4:0]        inorder,
  output logic [31:0]       indata,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              sb_err
);

  import wb_pkg::*;

  rr_ptr_t     rr_q, rr_d;
  logic [31:0] pending_q, pending_d;
  logic        wea_q, wea_d;
  logic [4:0]  inorder_q, inorder_d;
  logic [31:0] indata_q, indata_d;
  logic        sb_err_q, sb_err_d;

  logic [2:0]  grant;
  logic        grant_any;
  rr_ptr_t     grant_idx;
  rr_ptr_t     next_ptr;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        iss_fire;

  rr_arbiter3 u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_q),
    .grant     (grant),
    .grant_any (grant_any),
    .grant_idx (grant_idx),
    .next_ptr  (next_ptr)
  );

  assign req_ready = grant;

  always_comb begin
    case (grant_idx)
      WB_MDU: begin
        sel_rd   = req_rd[9:5];
        sel_data = req_data[63:32];
      end
      WB_LOAD: begin
        sel_rd   = req_rd[14:10];
        sel_data = req_data[95:64];
      end
      default: begin
        sel_rd   = req_rd[4:0];
        sel_data = req_data[31:0];
      end
    endcase
  end

  assign iss_ready = !pending_q[iss_rd] | (iss_rd == 5'd0);
  assign iss_fire  = iss_valid & iss_ready & (iss_rd != 5'd0);

  always_comb begin
    pending_d = pending_q;
    // Retire clears at the same edge the regfile commits the write.
    if (wea_q) pending_d[inorder_q] = 1'b0;
    if (iss_fire) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;

    wea_d     = grant_any & (sel_rd != 5'd0);
    inorder_d = grant_any ? sel_rd : inorder_q;
    indata_d  = grant_any ? sel_data : indata_q;
    sb_err_d  = sb_err_q |
                (grant_any & (sel_rd != 5'd0) & !pending_q[sel_rd]);
    rr_d      = next_ptr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      rr_q      <= WB_ALU;
      wea_q     <= 1'b0;
      inorder_q <= '0;
      indata_q  <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      wea_q     <= wea_d;
      inorder_q <= inorder_d;
      indata_q  <= indata_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign wea     = wea_q;
  assign inorder = inorder_q;
  assign indata  = indata_q;
  assign sb_err  = sb_err_q;
  assign rs_busy = pending_q[rs_addr];
  assign rt_busy = pending_q[rt_addr];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with hand-computed expectations.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wea;
  logic [4:0]  inorder;
  logic [31:0] indata;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_busy, rt_busy;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NREQ(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wea       (wea),
    .inorder   (inorder),
    .indata    (indata),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .sb_err    (sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    req_valid = 3'b000;
    req_rd    = '0;
    req_data  = '0;
    rs_addr   = 5'd0;
    rt_addr   = 5'd0;
    #2;
    chk("rst_wea", {31'd0, wea}, 32'd0);
    chk("rst_inorder", {27'd0, inorder}, 32'd0);
    chk("rst_indata", indata, 32'd0);
    chk("rst_sb_err", {31'd0, sb_err}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Issue r5, MDU returns 0xA5
    iss_valid = 1'b1; iss_rd = 5'd5; rt_addr = 5'd5;
    settle();
    chk("iss5_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    settle();
    chk("r5_busy_issued", {31'd0, rt_busy}, 32'd1);
    req_valid = 3'b010; req_rd[9:5] = 5'd5; req_data[63:32] = 32'h0000_00A5;
    settle();
    chk("mdu_grant", {29'd0, req_ready}, 32'h2);
    tick();
    req_valid = 3'b000;
    settle();
    chk("mdu_wea", {31'd0, wea}, 32'd1);
    chk("mdu_inorder", {27'd0, inorder}, 32'd5);
    chk("mdu_indata", indata, 32'h0000_00A5);
    chk("r5_busy_wea", {31'd0, rt_busy}, 32'd1);
    tick();
    chk("mdu_wea_drop", {31'd0, wea}, 32'd0);
    chk("r5_busy_retired", {31'd0, rt_busy}, 32'd0);
    chk("mdu_sb_err", {31'd0, sb_err}, 32'd0);

    // LOAD writes r0: accepted, dropped (pointer now at LOAD)
    req_valid = 3'b100; req_rd[14:10] = 5'd0; req_data[95:64] = 32'hDEAD_BEEF;
    settle();
    chk("r0_grant", {29'd0, req_ready}, 32'h4);
    tick();
    req_valid = 3'b000;
    settle();
    chk("r0_wea", {31'd0, wea}, 32'd0);
    chk("r0_sb_err", {31'd0, sb_err}, 32'd0);

    // Round robin with all three valid, pointer at ALU
    for (int r = 1; r <= 4; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    settle();
    chk("rr_g0", {29'd0, req_ready}, 32'h1);
    tick();
    req_rd[4:0] = 5'd4; req_data[31:0] = 32'h44;
    settle();
    chk("rr_w1_wea", {31'd0, wea}, 32'd1);
    chk("rr_w1_rd", {27'd0, inorder}, 32'd1);
    chk("rr_w1_data", indata, 32'h11);
    chk("rr_g1", {29'd0, req_ready}, 32'h2);
    tick();
    chk("rr_w2_wea", {31'd0, wea}, 32'd1);
    chk("rr_w2_rd", {27'd0, inorder}, 32'd2);
    chk("rr_g2", {29'd0, req_ready}, 32'h4);
    tick();
    chk("rr_w3_wea", {31'd0, wea}, 32'd1);
    chk("rr_w3_rd", {27'd0, inorder}, 32'd3);
    chk("rr_g3", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    rs_addr = 5'd4;
    settle();
    chk("rr_w4_wea", {31'd0, wea}, 32'd1);
    chk("rr_w4_rd", {27'd0, inorder}, 32'd4);
    chk("rr_w4_data", indata, 32'h44);
    tick();
    chk("rr_idle_wea", {31'd0, wea}, 32'd0);
    chk("rr_r4_busy", {31'd0, rs_busy}, 32'd0);
    chk("rr_sb_err", {31'd0, sb_err}, 32'd0);

    // WAW stall on r7 (pointer at MDU, only ALU valid)
    iss_valid = 1'b1; iss_rd = 5'd7;
    settle();
    chk("r7_first_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    settle();
    chk("r7_waw_stall", {31'd0, iss_ready}, 32'd0);
    req_valid = 3'b001; req_rd[4:0] = 5'd7; req_data[31:0] = 32'h77;
    settle();
    chk("r7_grant", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    iss_valid = 1'b0;
    settle();
    chk("r7_wea", {31'd0, wea}, 32'd1);
    chk("r7_stall_wea", {31'd0, iss_ready}, 32'd0);
    tick();
    chk("r7_ready_after", {31'd0, iss_ready}, 32'd1);

    // ALU writes r9 never issued: sticky error
    req_valid = 3'b001; req_rd[4:0] = 5'd9; req_data[31:0] = 32'h99;
    settle();
    chk("r9_grant", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    settle();
    chk("r9_wea", {31'd0, wea}, 32'd1);
    chk("r9_inorder", {27'd0, inorder}, 32'd9);
    chk("r9_sb_err", {31'd0, sb_err}, 32'd1);
    tick();
    tick();
    chk("r9_sb_err_sticky", {31'd0, sb_err}, 32'd1);

    // Reset mid-operation with r3, r4 pending (pointer at MDU)
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    rs_addr = 5'd3; rt_addr = 5'd4;
    req_valid = 3'b010; req_rd[9:5] = 5'd3; req_data[63:32] = 32'h1234_5678;
    settle();
    chk("mid_busy_r3", {31'd0, rs_busy}, 32'd1);
    chk("mid_busy_r4", {31'd0, rt_busy}, 32'd1);
    tick();
    req_valid = 3'b100; req_rd[14:10] = 5'd4; req_data[95:64] = 32'h8765_4321;
    settle();
    chk("mid_wea", {31'd0, wea}, 32'd1);
    reset_n = 1'b0;
    settle();
    chk("arst_wea", {31'd0, wea}, 32'd0);
    chk("arst_inorder", {27'd0, inorder}, 32'd0);
    chk("arst_indata", indata, 32'd0);
    chk("arst_sb_err", {31'd0, sb_err}, 32'd0);
    chk("arst_busy_r3", {31'd0, rs_busy}, 32'd0);
    chk("arst_busy_r4", {31'd0, rt_busy}, 32'd0);
    req_valid = 3'b000;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_busy_r3", {31'd0, rs_busy}, 32'd0);
    chk("post_busy_r4", {31'd0, rt_busy}, 32'd0);
    chk("post_wea", {31'd0, wea}, 32'd0);
    req_valid = 3'b111;
    settle();
    chk("post_ptr_grant", {29'd0, req_ready}, 32'h1);
    req_valid = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32×32 register file: arbitrates three result sources (ALU, multiply/divide unit, load unit) onto the single regfile write port and keeps a scoreboard of destination registers with results still in flight. Sits between the execute/memory stages and the regfile write port (`wea`/`inorder`/`indata`). Supplies read-hazard flags to the decode-stage stall logic.

## Interface
Parameters:
- `NREQ`, 3, number of write-back requesters (index 0 = ALU, 1 = MDU, 2 = LOAD); fixed at 3 for this release.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `iss_valid`  in  1  decode issues an instruction that will write `iss_rd`.
- `iss_rd`  in  5  destination register of the issued instruction.
- `iss_ready`  out  1  issue accepted; low when `iss_rd` is already pending (WAW stall).
- `req_valid`  in  NREQ  per-requester result valid.
- `req_rd`  in  NREQ×5  per-requester destination, packed `[5*i+4:5*i]`.
- `req_data`  in  NREQ×32  per-requester result, packed `[32*i+31:32*i]`.
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `wea`  out  1  regfile write enable, registered.
- `inorder`  out  5  regfile write address, registered.
- `indata`  out  32  regfile write data, registered.
- `rs_addr`, `rt_addr`  in  5  decode read addresses.
- `rs_busy`, `rt_busy`  out  1  addressed register pending (combinational).
- `sb_err`  out  1  sticky: a write-back targeted a non-pending, non-zero register.

## Operation
- Scoreboard: 32-bit `pending` vector; bit 0 is hardwired 0.
- Issue: `iss_ready = !pending[iss_rd] | (iss_rd == 0)`. On `iss_valid & iss_ready` with `iss_rd != 0`, set `pending[iss_rd]`.
- Arbitration: round-robin over valid requesters, starting at `rr_ptr`. At most one grant per cycle. `req_ready` depends only on `req_valid` and `rr_ptr`, never on `req_data`.
- Pointer update: after a grant to i, `rr_ptr <= (i+1) mod 3`. With no grant, `rr_ptr` holds.
- Output register: on a transfer, load `inorder <= req_rd[i]`, `indata <= req_data[i]`, and `wea <= (req_rd[i] != 0)`. With no transfer, `wea <= 0`, and `inorder`/`indata` hold.
- Retire: while `wea` = 1, clear `pending[inorder]` at the same edge the regfile commits.
- Issue and retire of the same register cannot occur in one cycle, because issue is blocked while that register is pending.
- Issue and retire of different registers in one cycle are both applied.
- `rs_busy = pending[rs_addr]`; `rt_busy = pending[rt_addr]`. Address 0 is never busy.
- `sb_err` sets on a transfer with `req_rd != 0` and `pending[req_rd] == 0`. The write still proceeds. `sb_err` clears only on reset.
- Writes to r0 are accepted (handshake completes) and dropped (`wea` = 0).

## Timing
- Reset (async assert, sync release) forces: `pending = 0`, `rr_ptr = 0`, `wea = 0`, `inorder = 0`, `indata = 0`, `sb_err = 0`.
- Reset mid-operation discards in-flight writes. Requesters must re-present after reset.
- Latency: transfer at edge T → `wea` high during cycle T..T+1 → regfile written and pending cleared at edge T+1. From T+1, `rs_busy` is low and the regfile reads the new value; no forwarding is required.
- Throughput: one write per cycle sustained.
- Starvation bound: a requester holding `req_valid` is granted within 3 cycles.
- A requester must hold `req_valid`, `req_rd` and `req_data` stable until its grant.

## Structure
- Shared package `wb_pkg` holds:
  - `NREQ = 3`
  - requester index constants `WB_ALU = 0`, `WB_MDU = 1`, `WB_LOAD = 2`
  - the `rr_ptr` type (2-bit, legal values 0–2)
- Sub-module `rr_arbiter3`: combinational one-hot grant from `req_valid` and `rr_ptr`, plus next-pointer output. The scoreboard and output register stay in `regfile_wb_ctrl`.

## Test plan
- Reset release, then issue r5, then MDU returns r5 = 0x0000_00A5 → `rt_busy` (with `rt_addr` = 5) is high until the edge after `wea`; `wea` = 1, `inorder` = 5, `indata` = 0xA5 one cycle after the grant.
- All three requesters valid continuously with `rr_ptr` = 0 (rd 1, 2, 3) → grants in order 0, 1, 2, 0…; `wea` high every cycle.
- Issue r7 while r7 is pending → `iss_ready` = 0; `iss_ready` rises the cycle after r7 retires.
- LOAD returns rd = 0 with data 0xDEAD_BEEF → handshake completes, `wea` stays 0, `sb_err` stays 0.
- ALU returns r9, never issued → r9 is written and `sb_err` goes to 1 and stays until `reset_n` is asserted.
- Assert `reset_n` low with r3 and r4 pending while a grant is in progress → all outputs return to their reset values asynchronously; after release, `rs_busy` is 0 for r3 and r4.
